// File: rtl/rep_execute_block_nlane.sv
// N-lane run-length expander: pops groups of LANES {oper,data} entries, emits <oper> copies
// of each data word packed densely into LANES-wide beats, with backpressure and partial flush.
module rep_execute_block_nlane #(
  parameter int DATA_W = 8,
  parameter int OPER_W = 4,
  parameter int LANES  = 2
) (
  input  logic                              clk,
  input  logic                              nReset,
  input  logic                              run,
  input  logic [LANES*(OPER_W+DATA_W)-1:0]  zip_data,
  input  logic                              in_empty,
  output logic                              rd_req,
  output logic [LANES*DATA_W-1:0]           data_out,
  output logic [LANES-1:0]                  data_out_mask,
  output logic                              data_out_vd_o,
  input  logic                              data_out_ready,
  output logic                              busy
);

  localparam int ENTRY_W = OPER_W + DATA_W;
  localparam int BUF_N   = 2 * LANES;
  localparam int CNT_W   = $clog2(BUF_N + 1);
  localparam int PTR_W   = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              armed_q;
  logic [OPER_W-1:0] grp_oper_q [LANES];
  logic [DATA_W-1:0] grp_data_q [LANES];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [OPER_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] pbuf_q [BUF_N];
  logic [DATA_W-1:0] pbuf_d [BUF_N];
  logic [CNT_W-1:0]  cnt_q, cnt_d, post_cnt, take;

  logic out_free, drain, append, entry_done, last_lane, group_done;
  logic fetch_go, flush_go, out_load;
  logic [LANES*DATA_W-1:0] out_data_d;
  logic [LANES-1:0]        out_mask_d;

  // Handshake and per-cycle control. A drain frees space before the append decision.
  always_comb begin
    out_free   = !data_out_vd_o || data_out_ready;
    drain      = (cnt_q >= CNT_W'(LANES)) && out_free;
    post_cnt   = drain ? cnt_q - CNT_W'(LANES) : cnt_q;
    take       = (int'(rem_q) >= LANES) ? CNT_W'(LANES) : CNT_W'(rem_q);
    last_lane  = (ptr_q == PTR_W'(LANES - 1));
    ptr_nxt    = last_lane ? ptr_q : ptr_q + 1'b1;
    append     = (state_q == S_EXPAND) && (rem_q != '0) && (post_cnt < CNT_W'(LANES));
    entry_done = (state_q == S_EXPAND) &&
                 ((rem_q == '0) || (append && (rem_q == OPER_W'(take))));
    group_done = entry_done && last_lane;
    fetch_go   = armed_q && run && !in_empty && ((state_q == S_IDLE) || group_done);
    flush_go   = (state_q == S_FLUSH) && out_free;
  end

  assign rd_req = fetch_go;
  assign busy   = (state_q != S_IDLE) || (cnt_q != '0) || data_out_vd_o;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    pbuf_d = pbuf_q;
    if (drain) begin
      for (int i = 0; i < LANES; i++)     pbuf_d[i] = pbuf_q[i + LANES];
      for (int i = LANES; i < BUF_N; i++) pbuf_d[i] = '0;
    end
    if (append) begin
      for (int i = 0; i < BUF_N; i++)
        if (i >= int'(post_cnt) && i < int'(post_cnt) + int'(take))
          pbuf_d[i] = grp_data_q[ptr_q];
    end
    cnt_d = post_cnt + (append ? take : '0);
    if (flush_go) begin
      cnt_d = '0;
      for (int i = 0; i < BUF_N; i++) pbuf_d[i] = '0;
    end
  end

  // Beat contents: a full drain takes the oldest LANES words; a flush takes only the cnt valid ones.
  always_comb begin
    out_load   = drain || flush_go;
    out_data_d = '0;
    out_mask_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (drain || (CNT_W'(i) < cnt_q)) begin
        out_data_d[i*DATA_W +: DATA_W] = pbuf_q[i];
        out_mask_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_go)
          state_d = S_FETCH;
        else if (!run && (cnt_q != '0) && (cnt_q < CNT_W'(LANES)))
          state_d = S_FLUSH;
      end
      S_FETCH: begin
        ptr_d   = '0;
        rem_d   = zip_data[DATA_W +: OPER_W];
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        if (entry_done) begin
          if (last_lane) begin
            rem_d   = '0;
            state_d = fetch_go ? S_FETCH : S_IDLE;
          end else begin
            ptr_d = ptr_nxt;
            rem_d = grp_oper_q[ptr_nxt];
          end
        end else if (append) begin
          rem_d = rem_q - OPER_W'(take);
        end
      end
      S_FLUSH: begin
        if (out_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the group register and pack buffer are reset too, so a reset discards any pending work.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b0;
      ptr_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      data_out      <= '0;
      data_out_mask <= '0;
      data_out_vd_o <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        grp_oper_q[i] <= '0;
        grp_data_q[i] <= '0;
      end
      for (int i = 0; i < BUF_N; i++) pbuf_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
      state_q <= state_d;
      armed_q <= 1'b1;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      pbuf_q  <= pbuf_d;
      if (state_q == S_FETCH) begin
        for (int i = 0; i < LANES; i++) begin
          grp_oper_q[i] <= zip_data[i*ENTRY_W + DATA_W +: OPER_W];
          grp_data_q[i] <= zip_data[i*ENTRY_W +: DATA_W];
        end
      end
      if (out_load) begin
        data_out      <= out_data_d;
        data_out_mask <= out_mask_d;
        data_out_vd_o <= 1'b1;
      end else if (data_out_vd_o && data_out_ready) begin
        data_out_vd_o <= 1'b0;
      end
    end
  end

endmodule
